sprite_cmd_sequencer: RTL and testbench

SPRITE_CMD_SEQUENCER -- requirements
Module: sprite_cmd_sequencer

---
 rtl/ppu_cmd_pkg.sv | 46 ++++
 rtl/cmd_word_pack.sv | 16 +
 rtl/sprite_cmd_sequencer.sv | 145 ++++++++++++++
 tb/tb_sprite_cmd_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/ppu_cmd_pkg.sv
// Shared command-word field layout, info/type codes and the sequencer state set
// used by the sprite command sequencer and its word packer.
package ppu_cmd_pkg;

    localparam int SUB_LSB   = 26;
    localparam int SUB_W     = 6;
    localparam int CHILD_LSB = 21;
    localparam int CHILD_W   = 5;
    localparam int INFO_LSB  = 17;
    localparam int INFO_W    = 4;
    localparam int TYPE_LSB  = 14;
    localparam int TYPE_W    = 3;
    localparam int PP_BIT    = 13;
    localparam int MSG_W     = 13;

    localparam logic [INFO_W-1:0] INFO_NONE  = 4'b0000;
    localparam logic [INFO_W-1:0] INFO_WRITE = 4'b0001;
    localparam logic [INFO_W-1:0] INFO_FLUSH = 4'b1111;

    localparam logic [TYPE_W-1:0] TYPE_NONE  = 3'b000;
    localparam logic [TYPE_W-1:0] TYPE_ATTR  = 3'b001;
    localparam logic [TYPE_W-1:0] TYPE_XPOS  = 3'b010;
    localparam logic [TYPE_W-1:0] TYPE_YPOS  = 3'b011;
    localparam logic [TYPE_W-1:0] TYPE_SHIFT = 3'b100;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ATTR  = 3'd1,
        XPOS  = 3'd2,
        YPOS  = 3'd3,
        SHIFT = 3'd4,
        FLUSH = 3'd5
    } state_e;

    typedef struct packed {
        logic [SUB_W-1:0]   sub_comp;
        logic [CHILD_W-1:0] child;
        logic               visible;
        logic               flip;
        logic [4:0]         pattern;
        logic [9:0]         x;
        logic [9:0]         y;
        logic [9:0]         shift;
    } obj_desc_t;

endpackage

// File: rtl/cmd_word_pack.sv
// Combinational packer: assembles one 32-bit display command word from its fields.
module cmd_word_pack
    import ppu_cmd_pkg::*;
(
    input  logic [SUB_W-1:0]   sub_comp_i,
    input  logic [CHILD_W-1:0] child_i,
    input  logic [INFO_W-1:0]  info_i,
    input  logic [TYPE_W-1:0]  type_i,
    input  logic               pp_selc_i,
    input  logic [MSG_W-1:0]   msg_i,
    output logic [31:0]        word_o
);

    assign word_o = {sub_comp_i, child_i, info_i, type_i, pp_selc_i, msg_i};

endmodule

// File: rtl/sprite_cmd_sequencer.sv
// Expands sprite descriptors into ATTR/XPOS/YPOS/SHIFT command words and inserts
// frame flush words between descriptors, flipping the ping-pong buffer after each flush.
module sprite_cmd_sequencer
    import ppu_cmd_pkg::*;
#(
    parameter bit SKIP_INVISIBLE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        obj_valid,
    output logic        obj_ready,
    input  logic [5:0]  obj_sub_comp,
    input  logic [4:0]  obj_child,
    input  logic        obj_visible,
    input  logic        obj_flip,
    input  logic [4:0]  obj_pattern,
    input  logic [9:0]  obj_x,
    input  logic [9:0]  obj_y,
    input  logic [9:0]  obj_shift,
    input  logic        frame_req,
    output logic        frame_ack,
    output logic [31:0] writedata,
    output logic        write,
    output logic        back_buf
);

    state_e      state_q, state_d;
    obj_desc_t   desc_q, desc_in, desc_src;
    logic        pending_q;
    logic        back_buf_q, back_buf_d;
    logic        write_q, frame_ack_q;
    logic [31:0] writedata_q, word_d;
    logic        accept;

    logic [SUB_W-1:0]   sub_d;
    logic [CHILD_W-1:0] child_d;
    logic [INFO_W-1:0]  info_d;
    logic [TYPE_W-1:0]  type_d;
    logic               pp_d;
    logic [MSG_W-1:0]   msg_d;

    assign desc_in = '{sub_comp: obj_sub_comp, child: obj_child, visible: obj_visible,
                       flip: obj_flip, pattern: obj_pattern, x: obj_x, y: obj_y,
                       shift: obj_shift};

    assign obj_ready = !reset && (state_q == IDLE) && !pending_q && !frame_req;
    assign accept    = obj_valid && obj_ready;
    // The ATTR word is built in the acceptance cycle, before desc_q holds the descriptor.
    assign desc_src  = accept ? desc_in : desc_q;

    always_comb begin
        state_d    = state_q;
        back_buf_d = back_buf_q;
        case (state_q)
            IDLE: begin
                if (pending_q || frame_req) state_d = FLUSH;
                else if (accept)            state_d = ATTR;
            end
            ATTR:    state_d = (SKIP_INVISIBLE && !desc_q.visible) ? IDLE : XPOS;
            XPOS:    state_d = YPOS;
            YPOS:    state_d = SHIFT;
            SHIFT:   state_d = IDLE;
            FLUSH: begin
                state_d    = IDLE;
                back_buf_d = !back_buf_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sub_d   = desc_src.sub_comp;
        child_d = desc_src.child;
        info_d  = INFO_WRITE;
        type_d  = TYPE_NONE;
        pp_d    = back_buf_d;
        msg_d   = '0;
        case (state_d)
            ATTR: begin
                type_d = TYPE_ATTR;
                msg_d  = {desc_src.visible, desc_src.flip, 6'b0, desc_src.pattern};
            end
            XPOS: begin
                type_d = TYPE_XPOS;
                msg_d  = {3'b0, desc_src.x};
            end
            YPOS: begin
                type_d = TYPE_YPOS;
                msg_d  = {3'b0, desc_src.y};
            end
            SHIFT: begin
                type_d = TYPE_SHIFT;
                msg_d  = {3'b0, desc_src.shift};
            end
            FLUSH: begin
                sub_d   = '0;
                child_d = '0;
                info_d  = INFO_FLUSH;
            end
            default: begin
                sub_d   = '0;
                child_d = '0;
                info_d  = INFO_NONE;
                pp_d    = 1'b0;
            end
        endcase
    end

    cmd_word_pack u_pack (
        .sub_comp_i (sub_d),
        .child_i    (child_d),
        .info_i     (info_d),
        .type_i     (type_d),
        .pp_selc_i  (pp_d),
        .msg_i      (msg_d),
        .word_o     (word_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            desc_q      <= '0;
            pending_q   <= 1'b0;
            back_buf_q  <= 1'b0;
            write_q     <= 1'b0;
            frame_ack_q <= 1'b0;
            writedata_q <= '0;
        end else begin
            state_q     <= state_d;
            // Requests seen while the flush word is out are absorbed by that flush.
            pending_q   <= (state_q == FLUSH) ? 1'b0 : (pending_q || frame_req);
            back_buf_q  <= back_buf_d;
            write_q     <= (state_d != IDLE);
            frame_ack_q <= (state_d == FLUSH);
            writedata_q <= word_d;
            if (accept) desc_q <= desc_in;
        end
    end

    assign writedata = writedata_q;
    assign write     = write_q;
    assign frame_ack = frame_ack_q;
    assign back_buf  = back_buf_q;

endmodule

// File: tb/tb_sprite_cmd_sequencer.sv
// Bench for sprite_cmd_sequencer: directed scenarios with literal words, then random
// traffic checked every cycle against a word-queue model of the command stream.
module tb_sprite_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        obj_valid, obj_ready;
    logic [5:0]  obj_sub_comp;
    logic [4:0]  obj_child;
    logic        obj_visible, obj_flip;
    logic [4:0]  obj_pattern;
    logic [9:0]  obj_x, obj_y, obj_shift;
    logic        frame_req, frame_ack;
    logic [31:0] writedata;
    logic        write, back_buf;

    int tests = 0;
    int fails = 0;

    sprite_cmd_sequencer #(.SKIP_INVISIBLE(1'b1)) dut (
        .clk(clk), .reset(reset), .obj_valid(obj_valid), .obj_ready(obj_ready),
        .obj_sub_comp(obj_sub_comp), .obj_child(obj_child), .obj_visible(obj_visible),
        .obj_flip(obj_flip), .obj_pattern(obj_pattern), .obj_x(obj_x), .obj_y(obj_y),
        .obj_shift(obj_shift), .frame_req(frame_req), .frame_ack(frame_ack),
        .writedata(writedata), .write(write), .back_buf(back_buf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: the stream of words still owed (front = word on the bus now), plus flush state.
    logic [31:0] mq[$];
    bit fnow = 0, pend = 0, mbb = 0, started = 0;

    function automatic logic [31:0] mk(input int sub, input int child, input int info,
                                       input int typ, input int pp, input int msg);
        return (sub << 26) | (child << 21) | (info << 17) | (typ << 14) | (pp << 13) | msg;
    endfunction

    function automatic bit exp_ready();
        return !reset && mq.size() == 0 && !fnow && !pend && !frame_req;
    endfunction

    always @(posedge clk) begin
        bit rdy;
        rdy = exp_ready();
        started = 1;
        if (reset) begin
            mq.delete();
            fnow = 0; pend = 0; mbb = 0;
        end else if (fnow) begin
            fnow = 0; mbb = !mbb; pend = 0;
        end else begin
            pend = pend | frame_req;
            if (mq.size() > 0) void'(mq.pop_front());
            else if (pend) fnow = 1;
            else if (obj_valid && rdy) begin
                mq.push_back(mk(obj_sub_comp, obj_child, 1, 1, mbb,
                                (obj_visible << 12) | (obj_flip << 11) | obj_pattern));
                if (obj_visible) begin
                    mq.push_back(mk(obj_sub_comp, obj_child, 1, 2, mbb, obj_x));
                    mq.push_back(mk(obj_sub_comp, obj_child, 1, 3, mbb, obj_y));
                    mq.push_back(mk(obj_sub_comp, obj_child, 1, 4, mbb, obj_shift));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            #2;
            chk("ready", obj_ready, exp_ready());
            chk("write", write, (fnow || mq.size() > 0));
            chk("writedata", writedata,
                fnow ? mk(0, 0, 15, 0, mbb, 0) : (mq.size() > 0 ? mq[0] : 32'h0));
            chk("frame_ack", frame_ack, fnow);
            chk("back_buf", back_buf, mbb);
        end
    end

    task automatic set_desc(input int sub, input int child, input int vis, input int flip,
                            input int pat, input int x, input int y, input int sh);
        obj_sub_comp = 6'(sub); obj_child = 5'(child); obj_visible = 1'(vis);
        obj_flip = 1'(flip); obj_pattern = 5'(pat);
        obj_x = 10'(x); obj_y = 10'(y); obj_shift = 10'(sh);
    endtask

    initial begin
        reset = 1; obj_valid = 0; frame_req = 0;
        set_desc(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("lit_rst_write", write, 0);
        reset = 0;
        #3 chk("lit_ready_after_rst", obj_ready, 1);

        // visible descriptor: four consecutive words
        @(negedge clk) set_desc(15, 2, 1, 0, 0, 100, 368, 5); obj_valid = 1;
        @(negedge clk) obj_valid = 0;
        #3 chk("lit_attr", writedata, 32'h3C425000);
        @(negedge clk) #3 chk("lit_xpos", writedata, 32'h3C428064);
        @(negedge clk) #3 chk("lit_ypos", writedata, 32'h3C42C170);
        @(negedge clk) #3 chk("lit_shift", writedata, 32'h3C430005);
        @(negedge clk) #3 chk("lit_idle_write", write, 0);

        // invisible descriptor: ATTR only
        @(negedge clk) set_desc(3, 4, 0, 0, 0, 9, 9, 9); obj_valid = 1;
        @(negedge clk) obj_valid = 0;
        #3 chk("lit_invis_attr", writedata, 32'h0C824000);
        @(negedge clk) #3 chk("lit_invis_ready", obj_ready, 1);

        // flush from IDLE, colliding with an offered descriptor
        @(negedge clk) frame_req = 1; set_desc(15, 2, 1, 0, 0, 100, 368, 5); obj_valid = 1;
        #3 chk("lit_flush_ready", obj_ready, 0);
        @(negedge clk) frame_req = 0; obj_valid = 0;
        #3 chk("lit_flush_word", writedata, 32'h001E0000);
        chk("lit_flush_ack", frame_ack, 1);
        @(negedge clk) #3 chk("lit_bb_toggle", back_buf, 1);
        @(negedge clk) obj_valid = 1;
        @(negedge clk) obj_valid = 0;
        #3 chk("lit_attr_pp1", writedata, 32'h3C427000);

        // repeated requests mid-descriptor: one flush after SHIFT
        @(negedge clk) frame_req = 1;
        @(negedge clk) frame_req = 0;
        #3 chk("lit_ypos_pp1", writedata, 32'h3C42E170);
        @(negedge clk) frame_req = 1;
        @(negedge clk) frame_req = 1;
        @(negedge clk) frame_req = 0;
        #3 chk("lit_flush_pp1", writedata, 32'h001E2000);
        @(negedge clk) #3 chk("lit_one_flush", write, 0);
        chk("lit_bb_back", back_buf, 0);

        // get back_buf to 1, then reset mid-descriptor in YPOS
        @(negedge clk) frame_req = 1;
        @(negedge clk) frame_req = 0;
        @(negedge clk) set_desc(7, 1, 1, 1, 3, 1, 2, 3); obj_valid = 1;
        @(negedge clk) obj_valid = 0;
        @(negedge clk);
        @(negedge clk) reset = 1;
        @(negedge clk) reset = 0;
        #3 chk("lit_rst_no_shift", write, 0);
        chk("lit_rst_bb", back_buf, 0);
        chk("lit_rst_ready", obj_ready, 1);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset     = ($urandom_range(0, 199) == 0);
            frame_req = ($urandom_range(0, 19) == 0);
            obj_valid = ($urandom_range(0, 9) < 6);
            set_desc($urandom, $urandom, $urandom_range(0, 3) != 0, $urandom, $urandom,
                     $urandom, $urandom, $urandom);
        end
        @(negedge clk) reset = 0; obj_valid = 0; frame_req = 0;
        repeat (8) @(negedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
